// File: rtl/i2c_wb_sequencer.sv
// i2c_wb_sequencer: turns one I2C byte request into the IICMB register command
// sequence over a single-beat Wishbone master port and reports one response.
//
//   state       | meaning
//   ST_ENABLE   | write CSR=0xC0 (core + irq enable)
//   ST_IDLE     | ready for a request
//   ST_DPR_WR   | write the step operand to DPR
//   ST_CMD_WR   | write the step command to CMDR
//   ST_WAIT_IRQ | wait for the controller interrupt, with timeout
//   ST_STAT_RD  | read CMDR status (clears irq) and decide the next step
//   ST_DATA_RD  | read DPR to fetch the received byte
//   ST_RESP     | one-cycle response strobe
module i2c_wb_sequencer #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    input  logic                  ack_i,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [3:0]            req_bus_i,
    input  logic [6:0]            req_addr_i,
    input  logic [7:0]            req_data_i,
    output logic                  rsp_valid_o,
    output logic [7:0]            rsp_data_o,
    output logic [1:0]            rsp_status_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [ADDR_WIDTH-1:0] REG_CSR  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] REG_DPR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] REG_CMDR = ADDR_WIDTH'(2);

    typedef enum logic [2:0] {
        ST_ENABLE, ST_IDLE, ST_DPR_WR, ST_CMD_WR,
        ST_WAIT_IRQ, ST_STAT_RD, ST_DATA_RD, ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        STEP_BUS, STEP_START, STEP_ADDR, STEP_DATA, STEP_STOP
    } step_t;

    state_t                state_q, state_d;
    step_t                 step_q, step_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [3:0]            bus_q, bus_d;
    logic [6:0]            addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            rd_byte_q, rd_byte_d;
    logic                  nak_q, nak_d;
    logic                  rerun_q, rerun_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [7:0]            rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_status_q, rsp_status_d;

    logic                  acc_en;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [7:0]            acc_dat;
    logic [7:0]            step_operand;
    logic [7:0]            step_cmd;
    logic                  wb_done;

    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;

    // State, request and Wishbone output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_ENABLE;
            step_q       <= STEP_BUS;
            cnt_q        <= '0;
            rw_q         <= 1'b0;
            bus_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rd_byte_q    <= '0;
            nak_q        <= 1'b0;
            rerun_q      <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            bus_q        <= bus_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rd_byte_q    <= rd_byte_d;
            nak_q        <= nak_d;
            rerun_q      <= rerun_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Next-state, step sequencing and single-beat Wishbone access control.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        bus_d        = bus_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rd_byte_d    = rd_byte_q;
        nak_d        = nak_q;
        rerun_d      = rerun_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        acc_en       = 1'b0;
        acc_we       = 1'b0;
        acc_adr      = REG_CSR;
        acc_dat      = 8'h00;
        wb_done      = 1'b0;

        case (step_q)
            STEP_BUS:  step_operand = {4'h0, bus_q};
            STEP_ADDR: step_operand = {addr_q, rw_q};
            default:   step_operand = data_q;
        endcase

        case (step_q)
            STEP_BUS:   step_cmd = 8'h06;
            STEP_START: step_cmd = 8'h04;
            STEP_ADDR:  step_cmd = 8'h01;
            STEP_DATA:  step_cmd = rw_q ? 8'h03 : 8'h01;
            default:    step_cmd = 8'h05;
        endcase

        case (state_q)
            ST_ENABLE:  begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_CSR;  acc_dat = 8'hC0; end
            ST_DPR_WR:  begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_DPR;  acc_dat = step_operand; end
            ST_CMD_WR:  begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = step_cmd; end
            ST_STAT_RD: begin acc_en = 1'b1; acc_adr = REG_CMDR; end
            ST_DATA_RD: begin acc_en = 1'b1; acc_adr = REG_DPR; end
            default:    ;
        endcase

        // Launch from an idle bus, drop everything on the ack edge; the state
        // change on that edge guarantees one idle cycle before the next launch.
        if (acc_en) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                we_d  = acc_we;
                adr_d = acc_adr;
                dat_d = DATA_WIDTH'(acc_dat);
            end else if (ack_i) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                adr_d   = '0;
                dat_d   = '0;
                wb_done = 1'b1;
            end
        end

        case (state_q)
            ST_ENABLE: begin
                if (wb_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid_i) begin
                    rw_d         = req_rw_i;
                    bus_d        = req_bus_i;
                    addr_d       = req_addr_i;
                    data_d       = req_data_i;
                    rd_byte_d    = 8'h00;
                    nak_d        = 1'b0;
                    rsp_data_d   = 8'h00;
                    rsp_status_d = 2'b00;
                    step_d       = STEP_BUS;
                    state_d      = ST_DPR_WR;
                end
            end
            ST_DPR_WR: begin
                if (wb_done) state_d = ST_CMD_WR;
            end
            ST_CMD_WR: begin
                if (wb_done) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_WAIT_IRQ: begin
                if (irq_i) begin
                    state_d = ST_STAT_RD;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_status_d = 2'b11;
                    rerun_d      = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STAT_RD: begin
                if (wb_done) begin
                    if (dat_i[4]) begin
                        rsp_status_d = 2'b11;
                        state_d      = ST_RESP;
                    end else if (dat_i[5]) begin
                        rsp_status_d = 2'b10;
                        state_d      = ST_RESP;
                    end else if (dat_i[6]) begin
                        // Only a NAK from the slave leaves the bus owned; release it first.
                        if (step_q == STEP_ADDR || (step_q == STEP_DATA && !rw_q)) begin
                            nak_d   = 1'b1;
                            step_d  = STEP_STOP;
                            state_d = ST_CMD_WR;
                        end else begin
                            rsp_status_d = 2'b01;
                            state_d      = ST_RESP;
                        end
                    end else if (dat_i[7]) begin
                        case (step_q)
                            STEP_BUS: begin
                                step_d  = STEP_START;
                                state_d = ST_CMD_WR;
                            end
                            STEP_START: begin
                                step_d  = STEP_ADDR;
                                state_d = ST_DPR_WR;
                            end
                            STEP_ADDR: begin
                                step_d  = STEP_DATA;
                                state_d = rw_q ? ST_CMD_WR : ST_DPR_WR;
                            end
                            STEP_DATA: begin
                                if (rw_q) begin
                                    state_d = ST_DATA_RD;
                                end else begin
                                    step_d  = STEP_STOP;
                                    state_d = ST_CMD_WR;
                                end
                            end
                            default: begin
                                rsp_status_d = nak_q ? 2'b01 : 2'b00;
                                rsp_data_d   = (rw_q && !nak_q) ? rd_byte_q : 8'h00;
                                state_d      = ST_RESP;
                            end
                        endcase
                    end else begin
                        rsp_status_d = 2'b11;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_DATA_RD: begin
                if (wb_done) begin
                    rd_byte_d = dat_i[7:0];
                    step_d    = STEP_STOP;
                    state_d   = ST_CMD_WR;
                end
            end
            ST_RESP: begin
                rerun_d = 1'b0;
                state_d = rerun_q ? ST_ENABLE : ST_IDLE;
            end
            default: state_d = ST_ENABLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Testbench for i2c_wb_sequencer: Wishbone/IICMB slave model with random ack
// and irq latency, a transaction-level reference model filling a scoreboard,
// and a monitor comparing every response and its bus access history.
module tb_i2c_wb_sequencer;

    localparam int TO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       irq_i;
    logic       cyc_o, stb_o, ack_i, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rw_i = 1'b0;
    logic [3:0] req_bus_i = 4'h0;
    logic [6:0] req_addr_i = 7'h00;
    logic [7:0] req_data_i = 8'h00;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic [1:0] rsp_status_o;

    i2c_wb_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .adr_o(adr_o),
        .we_o(we_o), .dat_o(dat_o), .dat_i(dat_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] st;
        logic [7:0] d;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [10:0] exp_log[$];
    logic [10:0] act_log[$];
    logic [7:0]  stat_tab[8];
    int          noirq_idx = -1;
    logic [7:0]  rd_val = 8'h00;
    int          n_cmdw = 0;
    int          cur_cmd = 0;
    bit          need_en = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_ok();
        for (int i = 0; i < 8; i++) stat_tab[i] = 8'h80;
        noirq_idx = -1;
    endtask

    // Walks the command list of one request at transaction level and records
    // every bus access it implies plus the final response.
    task automatic model_txn(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                             input logic [7:0] data);
        logic [7:0] ops[5];
        logic [7:0] cmds[5];
        bit         hasop[5];
        logic [1:0] st;
        logic [7:0] d;
        logic [7:0] sv;
        bit         nak;
        bit         tmo;
        int         k;
        rsp_t       r;
        st = 2'd0; d = 8'h00; nak = 1'b0; tmo = 1'b0; k = 0;
        ops[0] = {4'h0, bus}; ops[1] = 8'h00; ops[2] = {addr, rw}; ops[3] = data; ops[4] = 8'h00;
        cmds[0] = 8'h06; cmds[1] = 8'h04; cmds[2] = 8'h01;
        cmds[3] = rw ? 8'h03 : 8'h01; cmds[4] = 8'h05;
        hasop[0] = 1'b1; hasop[1] = 1'b0; hasop[2] = 1'b1; hasop[3] = !rw; hasop[4] = 1'b0;
        if (need_en) exp_log.push_back({1'b1, 2'd0, 8'hC0});
        need_en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (nak && s != 4) continue;
            if (hasop[s]) exp_log.push_back({1'b1, 2'd1, ops[s]});
            exp_log.push_back({1'b1, 2'd2, cmds[s]});
            if (k == noirq_idx) begin st = 2'd3; tmo = 1'b1; break; end
            exp_log.push_back({1'b0, 2'd2, 8'h00});
            sv = stat_tab[k];
            k++;
            if (sv[4]) begin st = 2'd3; break; end
            if (sv[5]) begin st = 2'd2; break; end
            if (sv[6]) begin
                if (s == 2 || (s == 3 && !rw)) begin nak = 1'b1; continue; end
                st = 2'd1;
                break;
            end
            if (!sv[7]) begin st = 2'd3; break; end
            if (s == 3 && rw) exp_log.push_back({1'b0, 2'd1, 8'h00});
            if (s == 4) begin
                st = nak ? 2'd1 : 2'd0;
                d  = (rw && !nak) ? rd_val : 8'h00;
            end
        end
        if (tmo) need_en = 1'b1;
        r.st = st;
        r.d  = d;
        exp_q.push_back(r);
    endtask

    // Wishbone slave standing in for the IICMB controller.
    initial begin : wb_slave
        int irq_cnt;
        ack_i = 1'b0; irq_i = 1'b0; dat_i = 8'h00; irq_cnt = -1;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                ack_i = 1'b0; irq_i = 1'b0; irq_cnt = -1;
            end else begin
                if (irq_cnt == 0) irq_i = 1'b1;
                if (irq_cnt >= 0) irq_cnt--;
                if (ack_i) begin
                    ack_i = 1'b0;
                end else if (cyc_o && stb_o && ($urandom_range(0, 1) == 1)) begin
                    ack_i = 1'b1;
                    act_log.push_back({we_o, adr_o, we_o ? dat_o : 8'h00});
                    if (we_o && adr_o == 2'd2) begin
                        cur_cmd = n_cmdw;
                        n_cmdw++;
                        if (cur_cmd != noirq_idx) irq_cnt = $urandom_range(0, 4);
                    end
                    if (!we_o) begin
                        if (adr_o == 2'd2) begin
                            dat_i = stat_tab[cur_cmd & 7];
                            irq_i = 1'b0;
                        end else begin
                            dat_i = (adr_o == 2'd1) ? rd_val : 8'h00;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard and compares response and accesses.
    initial begin : monitor
        rsp_t e;
        int   n;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_status", 32'(rsp_status_o), 32'(e.st));
                    check("rsp_data", 32'(rsp_data_o), 32'(e.d));
                    check("wb_access_count", act_log.size(), exp_log.size());
                    n = (act_log.size() < exp_log.size()) ? act_log.size() : exp_log.size();
                    for (int i = 0; i < n; i++)
                        check($sformatf("wb_access[%0d] {we,adr,dat}", i), 32'(act_log[i]), 32'(exp_log[i]));
                end
                act_log.delete();
                exp_log.delete();
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 1000) begin
            @(negedge clk_i);
            guard++;
        end
        if (req_ready_o !== 1'b1) check("ready_timeout", 32'(req_ready_o), 1);
    endtask

    task automatic issue(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                         input logic [7:0] data);
        wait_ready();
        req_rw_i    = rw;
        req_bus_i   = bus;
        req_addr_i  = addr;
        req_data_i  = data;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("busy_ready", 32'(req_ready_o), 0);
    endtask

    task automatic run_txn(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                           input logic [7:0] data);
        int guard;
        wait_ready();
        n_cmdw = 0;
        model_txn(rw, bus, addr, data);
        issue(rw, bus, addr, data);
        guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk_i);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_log.delete();
            act_log.delete();
        end
        @(negedge clk_i);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       rw;
        int         guard;
        set_ok();
        repeat (3) @(negedge clk_i);
        check("reset_cyc", 32'(cyc_o), 0);
        check("reset_stb", 32'(stb_o), 0);
        check("reset_we", 32'(we_o), 0);
        check("reset_adr", 32'(adr_o), 0);
        check("reset_dat", 32'(dat_o), 0);
        check("reset_ready", 32'(req_ready_o), 0);
        check("reset_rsp_valid", 32'(rsp_valid_o), 0);
        check("reset_rsp_data", 32'(rsp_data_o), 0);
        check("reset_rsp_status", 32'(rsp_status_o), 0);
        rst_i = 1'b0;

        set_ok();
        run_txn(1'b0, 4'd2, 7'h22, 8'h5A);
        set_ok(); rd_val = 8'hA7;
        run_txn(1'b1, 4'd1, 7'h22, 8'h00);
        set_ok(); stat_tab[2] = 8'hC0;
        run_txn(1'b0, 4'd3, 7'h22, 8'h11);
        set_ok(); stat_tab[1] = 8'h20;
        run_txn(1'b1, 4'd0, 7'h50, 8'h00);
        set_ok(); noirq_idx = 0;
        run_txn(1'b0, 4'd5, 7'h10, 8'h33);

        for (int t = 0; t < 45; t++) begin
            set_ok();
            rw     = 1'($urandom_range(0, 1));
            rd_val = 8'($urandom);
            case ($urandom_range(0, 5))
                2: stat_tab[rw ? 2 : $urandom_range(2, 3)] = 8'hC0;
                3: stat_tab[$urandom_range(0, 4)] = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'hA0;
                4: stat_tab[$urandom_range(0, 4)] = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'hB0;
                5: noirq_idx = $urandom_range(0, 4);
                default: ;
            endcase
            run_txn(rw, 4'($urandom), 7'($urandom), 8'($urandom));
        end

        // Reset while a Wishbone strobe is active: abandoned, no response.
        set_ok();
        wait_ready();
        n_cmdw = 0;
        issue(1'b0, 4'd4, 7'h3C, 8'h99);
        guard = 0;
        while (stb_o !== 1'b1 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        check("midreset_saw_stb", 32'(stb_o), 1);
        rst_i = 1'b1;
        #1;
        check("midreset_cyc", 32'(cyc_o), 0);
        check("midreset_stb", 32'(stb_o), 0);
        check("midreset_ready", 32'(req_ready_o), 0);
        check("midreset_rsp_valid", 32'(rsp_valid_o), 0);
        exp_q.delete();
        exp_log.delete();
        act_log.delete();
        need_en = 1'b1;
        repeat (3) @(negedge clk_i);
        act_log.delete();
        rst_i = 1'b0;
        repeat (60) @(negedge clk_i);

        for (int t = 0; t < 4; t++) begin
            set_ok();
            rd_val = 8'($urandom);
            run_txn(1'($urandom_range(0, 1)), 4'($urandom), 7'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
